mips: RTL and testbench
=======================

MIPS -- requirements
Module: mips

Interface
REQ-001 The block SHALL use clock clk, with reset named reset, synchronous and active-high.
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous active-high reset.
- interrupt  in  1  external interrupt request (hardware line IP[2]); level-sensitive.
- macroscopic_pc  out  32  address of the instruction architecturally executing this cycle.
- i_inst_addr  out  32  instruction fetch address (= PC).
- i_inst_rdata  in  32  instruction word; combinational, valid same cycle.
- m_data_addr  out  32  data memory byte address (ALU sum).
- m_data_rdata  in  32  word at m_data_addr & ~3; combinational.
- m_data_wdata  out  32  store data, byte-lane aligned.
- m_data_byteen  out  4  byte write enables; 0 = no store.
- m_inst_addr  out  32  PC of the instruction driving the memory ports.
- w_grf_we  out  1  register-file write enable this cycle.
- w_grf_addr  out  5  destination register.
- w_grf_wdata  out  32  value written.
- w_inst_addr  out  32  PC of the writing instruction.

Function
REQ-003 The block SHALL be a single-cycle MIPS-32 CPU: one instruction fetched, executed and committed per clock, with no branch delay slot; macroscopic_pc, i_inst_addr, m_inst_addr and w_inst_addr SHALL all equal PC.
REQ-004 The block SHALL support: addu, subu, and, or, slt, sll, jr, ori, addiu, lui, beq, bne, j, jal, lw, lh, lb, sw, sh, sb, mfc0, mtc0, eret.
- Any other opcode SHALL execute as nop.
REQ-005 Arithmetic SHALL wrap modulo 2^32 with no overflow trap.
- ori and lui zero-extend the immediate; addiu, loads and stores sign-extend it.
- slt compares signed.
REQ-006 Branch and jump targets:
- beq/bne target = PC+4+(sext(imm)<<2).
- j/jal target = {PC[31:28], idx, 00}.
- jal writes PC+4 to $31.
- jr jumps to rs.
- Otherwise next PC = PC+4.
REQ-007 The register file SHALL have 32x32 registers written at the rising edge.
- $0 always reads 0.
- w_grf_we SHALL be 0 for a destination of 0 and for instructions without a destination.
REQ-008 Store byte enables:
- sw: byteen 1111, wdata = rt.
- sh: byteen 0011 when addr[1]=0, 1100 when addr[1]=1; rt[15:0] replicated in both halves.
- sb: byteen one-hot at lane addr[1:0]; rt[7:0] replicated in all lanes.
- All other instructions: byteen 0000.
REQ-009 Loads SHALL select the lane by addr[1:0] and sign-extend (lb/lh); lw ignores addr[1:0]; no alignment exceptions.
REQ-010 CP0 registers, all others read 0 via mfc0:
- SR (12): IM=[15:10], EXL=[1], IE=[0].
- Cause (13): IP=[15:10] read-only, IP[2] mirrors interrupt live, ExcCode=[6:2] = 0.
- EPC (14): word-aligned.
REQ-011 An interrupt is taken in a cycle when interrupt & SR.IM[2] & SR.IE & ~SR.EXL.
- The instruction at PC SHALL be suppressed: byteen=0, w_grf_we=0, no CP0 or PC update.
- At the edge: EPC<=PC, EXL<=1, PC<=0x00004180.
REQ-012 eret SHALL set PC<=EPC and EXL<=0 in one cycle.
REQ-013 mtc0 SHALL write SR or EPC at the edge.
REQ-014 The block SHALL NOT clear interrupt; software acknowledges the device by a store to 0x7F20, which is presented on the ports like any store.

Reset
REQ-015 While reset=1:
- PC SHALL be 0x00003000 at the next edge.
- All GRF registers and SR/Cause/EPC SHALL clear to 0.
- m_data_byteen and w_grf_we SHALL be held 0.

Configuration
REQ-016 With macro MIPS_INT_EN defined, REQ-010..REQ-013 SHALL be implemented.
REQ-017 Without MIPS_INT_EN:
- interrupt SHALL be ignored.
- mfc0 SHALL write 0.
- mtc0 and eret SHALL act as nop.

Verification
REQ-018 Release reset -> i_inst_addr=0x3000 on the first cycle, then 0x3004.
REQ-019 ori $1,$0,0x1234 at 0x3000 -> w_grf_we=1, w_grf_addr=1, w_grf_wdata=0x00001234, w_inst_addr=0x3000.
REQ-020 $1=0x000000AB; sb $1,1($0) -> m_data_addr=1, byteen=0010, wdata[15:8]=0xAB. Then lb $2,1($0) with rdata=0x0000AB00 -> $2=0xFFFFFFAB.
REQ-021 beq $0,$0,+2 at 0x3008 -> next PC 0x3014. jal at 0x3014 -> $31=0x3018.
REQ-022 SR=0x00000401, interrupt=1 while PC=0x3010 -> no write that cycle, next PC 0x4180, EPC=0x3010, SR.EXL=1. Handler sw to 0x7F20 is emitted; eret -> PC 0x3010, EXL=0.
REQ-023 Same as REQ-022 without MIPS_INT_EN, or with SR.IE=0 -> execution continues at 0x3014.

Source files
------------

// File: rtl/mips.sv
// Single-cycle MIPS-32 core: fetch, execute and commit one instruction per clk; no delay slot.
// Build with MIPS_INT_EN defined to enable CP0 (SR/Cause/EPC), the external interrupt and mfc0/mtc0/eret.
module mips (
    input  logic        clk,
    input  logic        reset,
    input  logic        interrupt,
    output logic [31:0] macroscopic_pc,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] m_data_addr,
    input  logic [31:0] m_data_rdata,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    output logic [31:0] m_inst_addr,
    output logic        w_grf_we,
    output logic [4:0]  w_grf_addr,
    output logic [31:0] w_grf_wdata,
    output logic [31:0] w_inst_addr
);
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC   = 32'h0000_4180;

    logic [31:0] pc, pc_plus4, br_next, pc_next;
    logic [31:0] grf [32];
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm, lane_h;
    logic [7:0]  lane_b;
    logic [31:0] rs_val, rt_val, imm_s, sum, cp0_rdata, eret_pc;
    logic        we_raw, is_mtc0, is_eret, take_int, eret_go;
    logic [4:0]  waddr;
    logic [31:0] wdata, st_data;
    logic [3:0]  be_raw;

    assign op    = i_inst_rdata[31:26];
    assign rs    = i_inst_rdata[25:21];
    assign rt    = i_inst_rdata[20:16];
    assign rd    = i_inst_rdata[15:11];
    assign shamt = i_inst_rdata[10:6];
    assign funct = i_inst_rdata[5:0];
    assign imm   = i_inst_rdata[15:0];

    assign rs_val   = (rs == 5'd0) ? 32'd0 : grf[rs];
    assign rt_val   = (rt == 5'd0) ? 32'd0 : grf[rt];
    assign imm_s    = {{16{imm[15]}}, imm};
    assign sum      = rs_val + imm_s;
    assign pc_plus4 = pc + 32'd4;
    assign lane_h   = sum[1] ? m_data_rdata[31:16] : m_data_rdata[15:0];
    assign lane_b   = m_data_rdata[{sum[1:0], 3'b000} +: 8];

    always_comb begin
        br_next = pc_plus4;
        we_raw  = 1'b0;
        waddr   = rt;
        wdata   = 32'd0;
        be_raw  = 4'b0000;
        st_data = rt_val;
        is_mtc0 = 1'b0;
        is_eret = 1'b0;
        case (op)
            6'h00: begin
                waddr = rd;
                case (funct)
                    6'h21: begin we_raw = 1'b1; wdata = rs_val + rt_val; end
                    6'h23: begin we_raw = 1'b1; wdata = rs_val - rt_val; end
                    6'h24: begin we_raw = 1'b1; wdata = rs_val & rt_val; end
                    6'h25: begin we_raw = 1'b1; wdata = rs_val | rt_val; end
                    6'h2a: begin we_raw = 1'b1; wdata = {31'd0, $signed(rs_val) < $signed(rt_val)}; end
                    6'h00: begin we_raw = 1'b1; wdata = rt_val << shamt; end
                    6'h08: br_next = rs_val;
                    default: ;
                endcase
            end
            6'h0d: begin we_raw = 1'b1; wdata = rs_val | {16'd0, imm}; end
            6'h09: begin we_raw = 1'b1; wdata = sum; end
            6'h0f: begin we_raw = 1'b1; wdata = {imm, 16'd0}; end
            6'h04: if (rs_val == rt_val) br_next = pc_plus4 + {imm_s[29:0], 2'b00};
            6'h05: if (rs_val != rt_val) br_next = pc_plus4 + {imm_s[29:0], 2'b00};
            6'h02: br_next = {pc[31:28], i_inst_rdata[25:0], 2'b00};
            6'h03: begin
                br_next = {pc[31:28], i_inst_rdata[25:0], 2'b00};
                we_raw  = 1'b1;
                waddr   = 5'd31;
                wdata   = pc_plus4;
            end
            6'h23: begin we_raw = 1'b1; wdata = m_data_rdata; end
            6'h21: begin we_raw = 1'b1; wdata = {{16{lane_h[15]}}, lane_h}; end
            6'h20: begin we_raw = 1'b1; wdata = {{24{lane_b[7]}}, lane_b}; end
            6'h2b: be_raw = 4'b1111;
            6'h29: begin
                be_raw  = sum[1] ? 4'b1100 : 4'b0011;
                st_data = {2{rt_val[15:0]}};
            end
            6'h28: begin
                be_raw  = 4'b0001 << sum[1:0];
                st_data = {4{rt_val[7:0]}};
            end
            6'h10: begin
                if (rs == 5'd0) begin
                    we_raw = 1'b1;
                    wdata  = cp0_rdata;
                end else if (rs == 5'd4) begin
                    is_mtc0 = 1'b1;
                end else if (rs == 5'h10 && funct == 6'h18) begin
                    is_eret = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef MIPS_INT_EN
    logic [31:0] sr, epc;
    localparam logic [31:0] SR_MASK = 32'h0000_FC03;

    assign take_int = interrupt & sr[10] & sr[0] & ~sr[1];
    assign eret_go  = is_eret;
    assign eret_pc  = epc;

    always_comb begin
        case (rd)
            5'd12:   cp0_rdata = sr;
            5'd13:   cp0_rdata = {21'd0, interrupt, 10'd0};
            5'd14:   cp0_rdata = epc;
            default: cp0_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr  <= 32'd0;
            epc <= 32'd0;
        end else if (take_int) begin
            epc   <= pc;
            sr[1] <= 1'b1;
        end else if (is_eret) begin
            sr[1] <= 1'b0;
        end else if (is_mtc0) begin
            if (rd == 5'd12) sr <= rt_val & SR_MASK;
            else if (rd == 5'd14) epc <= {rt_val[31:2], 2'b00};
        end
    end
`else
    // CP0 absent: the interrupt line and mtc0/eret decodes are tied off, mfc0 returns 0.
    assign take_int  = interrupt & 1'b0;
    assign eret_go   = (is_eret | is_mtc0) & 1'b0;
    assign eret_pc   = 32'd0;
    assign cp0_rdata = 32'd0;
`endif

    assign pc_next = take_int ? EXC_PC : (eret_go ? eret_pc : br_next);

    assign macroscopic_pc = pc;
    assign i_inst_addr    = pc;
    assign m_inst_addr    = pc;
    assign w_inst_addr    = pc;
    assign m_data_addr    = sum;
    assign m_data_wdata   = st_data;
    assign m_data_byteen  = (reset | take_int) ? 4'b0000 : be_raw;
    assign w_grf_we       = we_raw & (waddr != 5'd0) & ~reset & ~take_int;
    assign w_grf_addr     = waddr;
    assign w_grf_wdata    = wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
            for (int i = 0; i < 32; i++) grf[i] <= 32'd0;
        end else begin
            pc <= pc_next;
            if (w_grf_we) grf[waddr] <= wdata;
        end
    end
endmodule

// File: tb/tb_mips.sv
// Scoreboard bench for mips: an instruction-level model predicts every cycle's port activity.
module tb_mips;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        interrupt = 1'b0;
    logic [31:0] macroscopic_pc, i_inst_addr, i_inst_rdata, m_data_addr, m_data_rdata;
    logic [31:0] m_data_wdata, m_inst_addr, w_grf_wdata, w_inst_addr;
    logic [3:0]  m_data_byteen;
    logic        w_grf_we;
    logic [4:0]  w_grf_addr;

    mips dut (
        .clk(clk), .reset(reset), .interrupt(interrupt),
        .macroscopic_pc(macroscopic_pc), .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata),
        .m_data_addr(m_data_addr), .m_data_rdata(m_data_rdata), .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr), .w_grf_we(w_grf_we),
        .w_grf_addr(w_grf_addr), .w_grf_wdata(w_grf_wdata), .w_inst_addr(w_inst_addr)
    );

    always #5 clk = ~clk;

`ifdef MIPS_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    typedef struct packed {
        logic        rst;
        logic        memop;
        logic [31:0] pc;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wv;
    } exp_t;

    logic [31:0] prog [64];
    logic [31:0] hprog [8];
    logic [31:0] dmem [256];
    bit          dm_init = 1'b0;
    exp_t        sb [$];
    int          checks = 0;
    int          failures = 0;

    // Reference model state
    logic [31:0] r [32];
    logic [31:0] m [256];
    logic [31:0] spc, ssr, sepc;

    assign i_inst_rdata = (i_inst_addr >= 32'h3000 && i_inst_addr < 32'h3100) ? prog[i_inst_addr[7:2]] :
                          (i_inst_addr >= 32'h4180 && i_inst_addr < 32'h41A0) ? hprog[i_inst_addr[4:2]] : 32'd0;
    assign m_data_rdata = dmem[m_data_addr[9:2]];

    always @(posedge clk) begin
        if (!dm_init) begin
            for (int i = 0; i < 256; i++) dmem[i] <= 32'd0;
            dm_init <= 1'b1;
        end else begin
            for (int k = 0; k < 4; k++)
                if (m_data_byteen[k]) dmem[m_data_addr[9:2]][8*k +: 8] <= m_data_wdata[8*k +: 8];
        end
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("byteen", 32'(m_data_byteen), 32'(e.be));
            chk("grf_we", 32'(w_grf_we), 32'(e.we));
            if (!e.rst) begin
                chk("macroscopic_pc", macroscopic_pc, e.pc);
                chk("i_inst_addr", i_inst_addr, e.pc);
                chk("m_inst_addr", m_inst_addr, e.pc);
                chk("w_inst_addr", w_inst_addr, e.pc);
                if (e.memop) chk("data_addr", m_data_addr, e.addr);
                if (e.be != 4'd0) chk("store_wdata", m_data_wdata, e.wd);
                if (e.we) begin
                    chk("grf_addr", 32'(w_grf_addr), 32'(e.wa));
                    chk("grf_wdata", w_grf_wdata, e.wv);
                end
            end
        end
    end

    function automatic logic [31:0] fetch(logic [31:0] a);
        if (a >= 32'h3000 && a < 32'h3100) return prog[(a - 32'h3000) / 4];
        if (a >= 32'h4180 && a < 32'h41A0) return hprog[(a - 32'h4180) / 4];
        return 32'd0;
    endfunction

    function automatic logic [31:0] cp0_read(logic [4:0] idx, logic intr);
        if (idx == 5'd12) return ssr;
        if (idx == 5'd13) return intr ? 32'h400 : 32'h0;
        if (idx == 5'd14) return sepc;
        return 32'd0;
    endfunction

    task automatic model_reset();
        spc = 32'h3000; ssr = 32'd0; sepc = 32'd0;
        for (int i = 0; i < 32; i++) r[i] = 32'd0;
    endtask

    // Executes one instruction at spc and describes what the ports should show.
    task automatic model_step(input logic intr, output exp_t e);
        logic [31:0] in, a, b, se, ea, nxt, val, w;
        logic [15:0] half;
        logic [7:0]  byt;
        int dest;
        in = fetch(spc);
        a = r[in[25:21]]; b = r[in[20:16]];
        se = 32'($signed(in[15:0]));
        ea = a + se; nxt = spc + 4; dest = 0; val = 32'd0;
        w = m[ea[9:2]];
        e = '0; e.pc = spc; e.addr = ea;
        if (INT_EN && intr && ssr[10] && ssr[0] && !ssr[1]) begin
            sepc = spc; ssr[1] = 1'b1; spc = 32'h4180;
            return;
        end
        case (in[31:26])
            6'h00: begin
                dest = int'(in[15:11]);
                case (in[5:0])
                    6'h21: val = a + b;
                    6'h23: val = a - b;
                    6'h24: val = a & b;
                    6'h25: val = a | b;
                    6'h2a: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h00: val = b << in[10:6];
                    6'h08: begin nxt = a; dest = 0; end
                    default: dest = 0;
                endcase
            end
            6'h0d: begin dest = int'(in[20:16]); val = a | {16'd0, in[15:0]}; end
            6'h09: begin dest = int'(in[20:16]); val = ea; end
            6'h0f: begin dest = int'(in[20:16]); val = {in[15:0], 16'd0}; end
            6'h04: if (a == b) nxt = spc + 4 + se * 4;
            6'h05: if (a != b) nxt = spc + 4 + se * 4;
            6'h02: nxt = {spc[31:28], in[25:0], 2'b00};
            6'h03: begin nxt = {spc[31:28], in[25:0], 2'b00}; dest = 31; val = spc + 4; end
            6'h23: begin e.memop = 1; dest = int'(in[20:16]); val = w; end
            6'h21: begin
                e.memop = 1; dest = int'(in[20:16]);
                half = 16'(w >> (ea[1] ? 16 : 0));
                val = 32'($signed(half));
            end
            6'h20: begin
                e.memop = 1; dest = int'(in[20:16]);
                byt = 8'(w >> (8 * int'(ea[1:0])));
                val = 32'($signed(byt));
            end
            6'h2b: begin e.memop = 1; e.be = 4'b1111; e.wd = b; end
            6'h29: begin e.memop = 1; e.be = ea[1] ? 4'b1100 : 4'b0011; e.wd = {2{b[15:0]}}; end
            6'h28: begin e.memop = 1; e.be = 4'(1 << ea[1:0]); e.wd = {4{b[7:0]}}; end
            6'h10: begin
                if (in[25:21] == 5'd0) begin
                    dest = int'(in[20:16]);
                    val = INT_EN ? cp0_read(in[15:11], intr) : 32'd0;
                end else if (INT_EN && in[25:21] == 5'd4) begin
                    if (in[15:11] == 5'd12) ssr = b & 32'h0000FC03;
                    else if (in[15:11] == 5'd14) sepc = b & 32'hFFFF_FFFC;
                end else if (INT_EN && in == 32'h4200_0018) begin
                    nxt = sepc; ssr[1] = 1'b0;
                end
            end
            default: ;
        endcase
        for (int k = 0; k < 4; k++)
            if (e.be[k]) m[ea[9:2]][8*k +: 8] = e.wd[8*k +: 8];
        if (dest != 0) begin
            e.we = 1'b1; e.wa = 5'(dest); e.wv = val; r[dest] = val;
        end
        spc = nxt;
    endtask

    function automatic logic [31:0] r_ins(int rs, int rt, int rd, int sh, int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction
    function automatic logic [31:0] i_ins(int op, int rs, int rt, logic [15:0] imm);
        return {6'(op), 5'(rs), 5'(rt), imm};
    endfunction
    function automatic logic [31:0] j_ins(int op, logic [31:0] tgt);
        return {6'(op), tgt[27:2]};
    endfunction
    function automatic logic [31:0] cop0(int sub, int rt, int rd);
        return {6'h10, 5'(sub), 5'(rt), 5'(rd), 11'd0};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic load_handler();
        hprog[0] = cop0(0, 18, 13);
        hprog[1] = i_ins('h2b, 0, 0, 16'h7F20);
        hprog[2] = cop0(0, 6, 14);
        hprog[3] = 32'h4200_0018;
        for (int i = 4; i < 8; i++) hprog[i] = 32'd0;
    endtask

    task automatic load_directed();
        for (int i = 0; i < 64; i++) prog[i] = 32'd0;
        prog[0]  = i_ins('h0d, 0, 1, 16'h1234);
        prog[1]  = i_ins('h0d, 0, 1, 16'h00AB);
        prog[2]  = i_ins('h04, 0, 0, 16'd2);
        prog[3]  = i_ins('h0d, 0, 5, 16'd1);
        prog[4]  = i_ins('h0d, 0, 5, 16'd2);
        prog[5]  = j_ins('h03, 32'h3020);
        prog[8]  = i_ins('h28, 0, 1, 16'd1);
        prog[9]  = i_ins('h20, 0, 2, 16'd1);
        prog[10] = i_ins('h29, 0, 2, 16'h0102);
        prog[11] = i_ins('h21, 0, 9, 16'h0102);
        prog[12] = i_ins('h0d, 0, 3, 16'h0401);
        prog[13] = cop0(4, 3, 12);
        prog[14] = cop0(0, 8, 12);
        prog[15] = i_ins('h0d, 0, 4, 16'h0004);
        prog[16] = r_ins(4, 1, 10, 0, 'h21);
        prog[17] = r_ins(0, 4, 11, 0, 'h23);
        prog[18] = r_ins(11, 4, 12, 0, 'h2a);
        prog[19] = r_ins(0, 1, 13, 4, 'h00);
        prog[20] = i_ins('h0f, 0, 14, 16'h8000);
        prog[21] = r_ins(14, 11, 15, 0, 'h24);
        prog[22] = i_ins('h23, 0, 16, 16'h0100);
        prog[23] = i_ins('h0d, 0, 7, 16'h306C);
        prog[24] = r_ins(7, 0, 0, 0, 'h08);
        prog[25] = i_ins('h0d, 0, 5, 16'd3);
        prog[26] = i_ins('h0d, 0, 5, 16'd4);
        prog[27] = i_ins('h05, 0, 0, 16'd5);
        prog[28] = i_ins('h09, 0, 17, 16'hFFFF);
        prog[29] = i_ins('h2b, 0, 17, 16'h0200);
        prog[30] = j_ins('h02, 32'h3078);
    endtask

    task automatic gen_random();
        int k, rs, rt, rd;
        logic [15:0] imm;
        for (int i = 0; i < 64; i++) begin
            k = $urandom_range(0, 22);
            rs = $urandom_range(0, 31); rt = $urandom_range(0, 31); rd = $urandom_range(0, 31);
            imm = 16'($urandom);
            case (k)
                0:  prog[i] = r_ins(rs, rt, rd, 0, 'h21);
                1:  prog[i] = r_ins(rs, rt, rd, 0, 'h23);
                2:  prog[i] = r_ins(rs, rt, rd, 0, 'h24);
                3:  prog[i] = r_ins(rs, rt, rd, 0, 'h25);
                4:  prog[i] = r_ins(rs, rt, rd, 0, 'h2a);
                5:  prog[i] = r_ins(0, rt, rd, $urandom_range(0, 31), 'h00);
                6:  prog[i] = i_ins('h0d, rs, rt, imm);
                7:  prog[i] = i_ins('h09, rs, rt, imm);
                8:  prog[i] = i_ins('h0f, 0, rt, imm);
                9:  prog[i] = i_ins('h04, rs, rt, 16'($urandom_range(0, 6)));
                10: prog[i] = i_ins('h05, rs, rt, 16'($urandom_range(0, 6)));
                11: prog[i] = j_ins('h02, 32'h3000 + 4 * $urandom_range(0, 63));
                12: prog[i] = j_ins('h03, 32'h3000 + 4 * $urandom_range(0, 63));
                13: prog[i] = i_ins('h23, rs, rt, imm);
                14: prog[i] = i_ins('h21, rs, rt, imm);
                15: prog[i] = i_ins('h20, rs, rt, imm);
                16: prog[i] = i_ins('h2b, rs, rt, imm);
                17: prog[i] = i_ins('h29, rs, rt, imm);
                18: prog[i] = i_ins('h28, rs, rt, imm);
                19: prog[i] = cop0(0, rt, $urandom_range(11, 15));
                20: prog[i] = cop0(4, rt, ($urandom_range(0, 1) == 0) ? 12 : 14);
                21: prog[i] = i_ins('h3f, rs, rt, imm);
                default: prog[i] = r_ins(rs, rt, rd, 0, 'h3f);
            endcase
        end
    endtask

    task automatic run_phase(input int ncyc, input bit rand_irq);
        exp_t e;
        bit dev, fired;
        dev = 1'b0; fired = 1'b0;
        reset = 1'b1; interrupt = 1'b0;
        e = '0; e.rst = 1'b1;
        sb.push_back(e); tick();
        sb.push_back(e); tick();
        model_reset();
        reset = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            if (rand_irq) dev = ($urandom_range(0, 3) == 0);
            else if (spc == 32'h303C && !fired) begin dev = 1'b1; fired = 1'b1; end
            interrupt = dev;
            model_step(dev, e);
            sb.push_back(e);
            if (!rand_irq && e.be != 4'd0 && e.addr == 32'h7F20) dev = 1'b0;
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m[i] = 32'd0;
        load_handler();
        tick();
        load_directed();
        run_phase(80, 1'b0);
        for (int p = 0; p < 3; p++) begin
            gen_random();
            run_phase(300, 1'b1);
        end
        for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expected cycles never observed", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
